// File: rtl/fetch_pc_controller_if.sv
// fetch_pc_controller_if: redirect/predict inputs and PC-to-fetch handshake of the fetch PC controller
interface fetch_pc_controller_if #(
  parameter int XLEN = 32
);
  logic            exception;
  logic [XLEN-1:0] exception_target;
  logic            mispredict;
  logic [XLEN-1:0] mispredict_target;
  logic            prediction;
  logic [XLEN-1:0] predicted_target;
  logic            instruction_length;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic            flush;
  logic [1:0]      fetch_epoch;
  modport slave (
    input  exception, exception_target, mispredict, mispredict_target,
           prediction, predicted_target, instruction_length, fetch_ready,
    output fetch_valid, fetch_pc, flush, fetch_epoch
  );
  modport master (
    output exception, exception_target, mispredict, mispredict_target,
           prediction, predicted_target, instruction_length, fetch_ready,
    input  fetch_valid, fetch_pc, flush, fetch_epoch
  );
endinterface

// File: rtl/fetch_pc_controller.sv
// fetch_pc_controller: owns the fetch PC, arbitrating exception > mispredict > prediction > sequential
module fetch_pc_controller #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input logic clk,
  input logic reset_n,
  fetch_pc_controller_if.slave bus
);
  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, target;
  logic [1:0]      epoch_q, epoch_d;
  logic            flush_q, redirect, handshake;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epoch_q <= 2'd0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      flush_q <= redirect;
    end
  // Redirects are ignored while booting; every other state leaves to FETCH unless redirected again.
  always_comb begin
    redirect  = state_q != BOOT && (bus.exception || bus.mispredict);
    handshake = state_q == FETCH && bus.fetch_ready;
    target    = bus.exception ? bus.exception_target : bus.mispredict_target;
    state_d   = redirect ? FLUSH : FETCH;
    epoch_d   = epoch_q + {1'b0, redirect};
    pc_d      = redirect ? {target[XLEN-1:1], 1'b0} :
                !handshake ? pc_q :
                bus.prediction ? {bus.predicted_target[XLEN-1:1], 1'b0} :
                pc_q + (bus.instruction_length ? XLEN'(4) : XLEN'(2));
  end
  assign bus.fetch_valid = state_q == FETCH;
  assign bus.fetch_pc    = pc_q;
  assign bus.flush       = flush_q;
  assign bus.fetch_epoch = epoch_q;
endmodule

// File: tb/tb_fetch_pc_controller.sv
// tb_fetch_pc_controller: directed and random scenarios checked against a cycle-level PC model
module tb_fetch_pc_controller;
  logic clk = 0;
  logic reset_n = 0;
  int vec = 0;
  int errs = 0;
  fetch_pc_controller_if #(.XLEN(32)) bus ();
  fetch_pc_controller #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] m_pc;
  logic [1:0]  m_ep;
  logic        m_valid, m_flush, m_boot;

  task model_reset();
    m_pc = 32'h0; m_ep = 2'd0; m_valid = 0; m_flush = 0; m_boot = 1;
  endtask

  task drive(input logic exc, input logic [31:0] et, input logic mis, input logic [31:0] mt,
             input logic pred, input logic [31:0] pt, input logic len, input logic rdy);
    bus.exception = exc; bus.exception_target = et;
    bus.mispredict = mis; bus.mispredict_target = mt;
    bus.prediction = pred; bus.predicted_target = pt;
    bus.instruction_length = len; bus.fetch_ready = rdy;
  endtask

  // Advance one clock; the model applies the rules to the inputs seen at that edge.
  task tick();
    if (m_boot) begin
      m_boot = 0; m_valid = 1; m_flush = 0;
    end else if (bus.exception || bus.mispredict) begin
      m_pc = (bus.exception ? bus.exception_target : bus.mispredict_target) & ~32'h1;
      m_ep = m_ep + 2'd1; m_flush = 1; m_valid = 0;
    end else begin
      if (m_valid && bus.fetch_ready)
        m_pc = bus.prediction ? (bus.predicted_target & ~32'h1) : m_pc + (bus.instruction_length ? 32'd4 : 32'd2);
      m_valid = 1; m_flush = 0;
    end
    @(posedge clk); #1;
  endtask

  task go_to(input logic [31:0] pc);
    drive(0, 0, 1, pc, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
  endtask

  task test_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    model_reset();
    reset_n = 0; #3;
    vec++;
    if ({bus.fetch_valid, bus.flush, bus.fetch_epoch, bus.fetch_pc} !== {1'b0, 1'b0, 2'd0, 32'h0}) begin
      errs++; $display("FAIL reset_state got v=%b f=%b e=%0d pc=%h", bus.fetch_valid, bus.flush, bus.fetch_epoch, bus.fetch_pc);
    end
    @(negedge clk); reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick(); vec++;
      if ({bus.fetch_valid, bus.flush, bus.fetch_epoch, bus.fetch_pc} !== {1'b1, 1'b0, 2'd0, 32'(i * 4)}) begin
        errs++; $display("FAIL boot_seq%0d got v=%b f=%b e=%0d pc=%h want v=1 f=0 e=0 pc=%h", i, bus.fetch_valid, bus.flush, bus.fetch_epoch, bus.fetch_pc, 32'(i * 4));
      end
    end
  endtask

  task test_mixed_lengths();
    logic [31:0] want [6] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h106, 32'h108};
    logic        lens [6] = '{0, 1, 1, 1, 1, 0};
    logic        rdys [6] = '{1, 0, 0, 0, 1, 1};
    go_to(32'h100);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, lens[i], rdys[i]); tick(); vec++;
      if (bus.fetch_pc !== want[i] || bus.fetch_pc !== m_pc || bus.fetch_valid !== 1'b1) begin
        errs++; $display("FAIL mixed%0d got pc=%h v=%b want pc=%h v=1", i, bus.fetch_pc, bus.fetch_valid, want[i]);
      end
    end
  endtask

  task test_prediction();
    logic [1:0] ep;
    go_to(32'h40);
    ep = bus.fetch_epoch;
    drive(0, 0, 0, 0, 1, 32'h2001, 1, 0); tick(); vec++;
    if (bus.fetch_pc !== 32'h40 || bus.fetch_valid !== 1'b1) begin
      errs++; $display("FAIL pred_stall got pc=%h v=%b want pc=00000040 v=1", bus.fetch_pc, bus.fetch_valid);
    end
    drive(0, 0, 0, 0, 1, 32'h2001, 1, 1); tick(); vec++;
    if ({bus.fetch_pc, bus.flush, bus.fetch_epoch} !== {32'h2000, 1'b0, ep}) begin
      errs++; $display("FAIL pred_taken got pc=%h f=%b e=%0d want pc=00002000 f=0 e=%0d", bus.fetch_pc, bus.flush, bus.fetch_epoch, ep);
    end
  endtask

  task test_simultaneous();
    logic [1:0] ep;
    ep = bus.fetch_epoch;
    drive(1, 32'h8000_0000, 1, 32'h500, 0, 0, 1, 1); tick(); vec++;
    if ({bus.fetch_valid, bus.flush, bus.fetch_epoch, bus.fetch_pc} !== {1'b0, 1'b1, 2'(ep + 2'd1), 32'h8000_0000}) begin
      errs++; $display("FAIL simul_redirect got v=%b f=%b e=%0d pc=%h want v=0 f=1 e=%0d pc=80000000", bus.fetch_valid, bus.flush, bus.fetch_epoch, bus.fetch_pc, 2'(ep + 2'd1));
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick(); vec++;
    if ({bus.fetch_valid, bus.flush, bus.fetch_pc} !== {1'b1, 1'b0, 32'h8000_0000}) begin
      errs++; $display("FAIL simul_valid got v=%b f=%b pc=%h want v=1 f=0 pc=80000000", bus.fetch_valid, bus.flush, bus.fetch_pc);
    end
  endtask

  task test_back_to_back();
    logic [1:0] ep;
    int nflush = 0;
    ep = bus.fetch_epoch;
    drive(0, 0, 1, 32'h500, 0, 0, 1, 1); tick(); nflush += bus.flush;
    drive(0, 0, 1, 32'h600, 0, 0, 1, 1); tick(); nflush += bus.flush;
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick(); nflush += bus.flush;
    vec++;
    if (nflush != 2 || bus.fetch_pc !== 32'h600 || bus.fetch_epoch !== 2'(ep + 2'd2) || bus.fetch_valid !== 1'b1) begin
      errs++; $display("FAIL b2b got flushes=%0d pc=%h e=%0d v=%b want flushes=2 pc=00000600 e=%0d v=1", nflush, bus.fetch_pc, bus.fetch_epoch, bus.fetch_valid, 2'(ep + 2'd2));
    end
    ep = bus.fetch_epoch;
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 32'h1000 + 32'(i), !i[0], 32'h2001 + 32'(i), 0, 0, 1, 1); tick(); vec++;
      if ({bus.flush, bus.fetch_epoch, bus.fetch_pc} !== {1'b1, 2'(ep + 2'(i + 1)), m_pc}) begin
        errs++; $display("FAIL epoch_wrap%0d got f=%b e=%0d pc=%h want f=1 e=%0d pc=%h", i, bus.flush, bus.fetch_epoch, bus.fetch_pc, 2'(ep + 2'(i + 1)), m_pc);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
  endtask

  task test_pc_wrap();
    go_to(32'hFFFF_FFFE);
    drive(0, 0, 0, 0, 0, 0, 1, 1); tick(); vec++;
    if (bus.fetch_pc !== 32'h2) begin
      errs++; $display("FAIL pc_wrap got pc=%h want pc=00000002", bus.fetch_pc);
    end
  endtask

  task test_reset_mid_flush();
    drive(0, 0, 1, 32'h700, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    reset_n = 0; model_reset(); #2; vec++;
    if ({bus.fetch_valid, bus.flush, bus.fetch_epoch, bus.fetch_pc} !== {1'b0, 1'b0, 2'd0, 32'h0}) begin
      errs++; $display("FAIL async_reset got v=%b f=%b e=%0d pc=%h want all zero", bus.fetch_valid, bus.flush, bus.fetch_epoch, bus.fetch_pc);
    end
    @(negedge clk); reset_n = 1;
  endtask

  task test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 3) == 0, $urandom, 1'($urandom), $urandom_range(0, 3) != 0);
      tick(); vec++;
      if ({bus.fetch_valid, bus.flush, bus.fetch_epoch, bus.fetch_pc} !== {m_valid, m_flush, m_ep, m_pc}) begin
        errs++; $display("FAIL random%0d got v=%b f=%b e=%0d pc=%h want v=%b f=%b e=%0d pc=%h", i, bus.fetch_valid, bus.flush, bus.fetch_epoch, bus.fetch_pc, m_valid, m_flush, m_ep, m_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mixed_lengths();
    test_prediction();
    test_simultaneous();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/fetch_pc_controller.md
# fetch_pc_controller

Owns the architectural fetch PC register of the out-of-order core and sequences it every cycle. Arbitrates between the commit-stage exception redirect, the execute-stage branch mispredict redirect, the branch-predictor target and the sequential next PC (+2 or +4 for compressed or full instructions). Presents the PC to the instruction fetch stage through a valid/ready handshake. Emits a flush pulse and a fetch epoch so in-flight fetches on a stale path can be discarded.

## Interface
- XLEN, 32, datapath width
- RESET_VECTOR, 32'h0000_0000, PC loaded at reset (XLEN bits)
- clk  input  1  core clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- exception  input  1  commit stage requests trap/return redirect
- exception_target  input  XLEN  redirect PC for exception
- mispredict  input  1  execute stage reports branch mispredict
- mispredict_target  input  XLEN  corrected PC
- prediction  input  1  predictor says the current fetch_pc is a taken branch
- predicted_target  input  XLEN  predicted next PC
- instruction_length  input  1  length of the instruction at fetch_pc: 1 = 32-bit (+4), 0 = compressed (+2)
- fetch_ready  input  1  fetch stage accepts fetch_pc this cycle
- fetch_valid  output  1  fetch_pc is valid for fetch
- fetch_pc  output  XLEN  PC presented to fetch
- flush  output  1  one-cycle pulse: discard all younger in-flight fetch/decode state
- fetch_epoch  output  2  path identifier, increments on every accepted redirect

## Operation
- States: BOOT, FETCH, FLUSH.
- Reset (asynchronous, while reset_n = 0):
  - state = BOOT, fetch_pc = RESET_VECTOR, fetch_valid = 0, flush = 0, fetch_epoch = 0.
- BOOT:
  - fetch_valid = 0.
  - Unconditionally goes to FETCH next cycle.
  - Redirect inputs are ignored in BOOT.
- Redirect priority, evaluated every cycle in FETCH and FLUSH: exception > mispredict.
- On a redirect:
  - fetch_pc <= target with bit 0 forced to 0.
  - fetch_epoch <= fetch_epoch + 1, modulo 4 with wrap 3 -> 0.
  - flush <= 1; state <= FLUSH.
  - A redirect is taken regardless of fetch_ready, and even when fetch_valid = 0.
- FETCH with no redirect, on handshake (fetch_valid & fetch_ready):
  - If prediction = 1: fetch_pc <= predicted_target & ~1.
  - Otherwise: fetch_pc <= fetch_pc + (instruction_length ? 4 : 2), truncated to XLEN (wraps at 2^XLEN).
  - prediction is not a redirect: no flush, epoch unchanged.
- FETCH with no handshake and no redirect: fetch_pc and fetch_valid hold.
  - prediction and instruction_length are sampled only on the handshake cycle.
- FLUSH:
  - fetch_valid = 0.
  - With no new redirect, goes to FETCH next cycle and flush <= 0.
  - A redirect arriving in FLUSH re-applies as above: state stays FLUSH, flush stays 1, epoch increments again.
- In FETCH, fetch_valid = 1.
- Simultaneous exception and mispredict: exception wins and mispredict is dropped. Epoch increments by 1 only.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Sequential advance: handshake in cycle N -> new fetch_pc visible in cycle N+1. Sustains 1 PC per cycle.
- Redirect asserted in cycle N:
  - N+1: fetch_pc = target, flush = 1, fetch_valid = 0, epoch updated.
  - N+2: fetch_valid = 1 if no further redirect.
  - Redirect-to-valid latency: 2 cycles.
- Reset deassertion: first rising edge moves BOOT -> FETCH. fetch_valid = 1 from the following cycle, with fetch_pc = RESET_VECTOR.
- Reset asserted mid-operation: all outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset release, fetch_ready = 1, instruction_length = 1 -> fetch_pc sequence 0x0, 0x4, 0x8, ... with fetch_valid = 1 from the second edge; flush = 0, epoch = 0.
- Mixed lengths from 0x100 (lengths 0, 1, 0) -> fetch_pc 0x100, 0x102, 0x106, 0x108. With fetch_ready = 0 for 3 cycles at 0x102, fetch_pc holds at 0x102.
- prediction = 1, predicted_target = 0x2001 at fetch_pc 0x40 with handshake -> next fetch_pc = 0x2000, no flush, epoch unchanged. Same stimulus with fetch_ready = 0 -> fetch_pc stays 0x40.
- exception (target 0x8000_0000) and mispredict (target 0x500) asserted in the same cycle -> next cycle fetch_pc = 0x8000_0000, flush = 1, fetch_valid = 0, epoch +1. fetch_valid = 1 one cycle later.
- Back-to-back mispredicts (0x500, then 0x600) during FLUSH -> flush high 2 cycles, final fetch_pc = 0x600, epoch +2. Five consecutive redirects -> epoch wraps 3 -> 0.
- fetch_pc = 0xFFFF_FFFE, length 1, handshake -> fetch_pc = 0x0000_0002. Assert reset_n = 0 mid-FLUSH -> fetch_pc = RESET_VECTOR, flush = 0, fetch_valid = 0 without a clock edge.
